rf_dump_reader: RTL and testbench
=================================

RF_DUMP_READER -- requirements
Module: rf_dump_reader

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of registers dumped (addresses 0..NUM_REGS-1).
REQ-002 SHALL have parameter ADDR_W, default 5, register address width.
REQ-003 SHALL have parameter DATA_W, default 32, register data width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a dump.
REQ-007 SHALL have port rd_addr  output  ADDR_W  register file read address (drives A1 or A2 of the register file).
REQ-008 SHALL have port rd_data  input  DATA_W  register file read data (RD1 or RD2), combinational from rd_addr.
REQ-009 SHALL have port out_valid  output  1  dump record valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts record.
REQ-011 SHALL have port out_regnum  output  ADDR_W  register number of current record.
REQ-012 SHALL have port out_data  output  DATA_W  register value of current record.
REQ-013 SHALL have port out_last  output  1  current record is register NUM_REGS-1.
REQ-014 SHALL have port busy  output  1  dump in progress (state != IDLE).
REQ-015 SHALL have port done  output  1  one-cycle pulse after the last record is accepted.

Function
REQ-016 SHALL implement FSM states IDLE, READ, HOLD and DONE.
REQ-017 IDLE: start=1 -> READ with rd_addr=0; otherwise remain in IDLE.
REQ-018 READ: SHALL register rd_data into out_data and rd_addr into out_regnum, then go to HOLD; out_valid=0 during READ.
REQ-019 HOLD: out_valid=1; out_regnum, out_data and out_last SHALL stay stable until out_valid&&out_ready.
REQ-020 HOLD with handshake, not last -> READ with rd_addr+1; last -> DONE.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE.
REQ-022 Throughput SHALL be one record per 2 cycles with out_ready held high; a full dump takes 2*NUM_REGS+2 cycles from start to done.
REQ-023 start while busy SHALL be ignored, with no restart and no queueing.
REQ-024 start in the DONE cycle SHALL be ignored; a new start is accepted only in IDLE.
REQ-025 out_last SHALL equal (out_regnum == NUM_REGS-1) while out_valid=1, and 0 otherwise.
REQ-026 The address counter SHALL NOT wrap past NUM_REGS-1 and SHALL NOT emit addresses >= NUM_REGS.
REQ-027 A register written between records SHALL be reported with its value at that record's READ cycle; the dump is not an atomic snapshot.
REQ-028 The block SHALL never drive register file write signals; it is read-only.
REQ-029 rd_addr SHALL hold its last value in IDLE/HOLD/DONE; the register file read is side-effect free.

Reset
REQ-030 On rst=1 at posedge clk: state=IDLE, rd_addr=0, out_valid=0, out_regnum=0, out_data=0, out_last=0, busy=0, done=0.
REQ-031 rst mid-dump SHALL abort immediately, with no done pulse and no partial record valid on the following cycle.
REQ-032 rst SHALL take priority over start in the same cycle.

Structure
REQ-033 A shared package SHALL hold the FSM state enum (IDLE/READ/HOLD/DONE) and the constants NUM_REGS=32 and ADDR_W=5 used by the register file.
REQ-034 The block SHALL be a single module with no sub-modules; the address counter and FSM are inline.

Verification
REQ-035 Preload reg i = 32'hA5A50000+i, pulse start, hold out_ready=1 -> 32 records in order 0..31, out_last only on 31, done exactly 66 cycles after start.
REQ-036 out_ready low for 5 cycles on record 7 -> out_valid held, regnum=7 and data stable, no skipped or duplicated records.
REQ-037 Pulse start at record 10 mid-dump -> ignored; sequence continues 11..31 with a single done.
REQ-038 Assert rst during HOLD of record 20 -> next cycle out_valid=0 and busy=0, no done; a subsequent start dumps from register 0.
REQ-039 Write reg 5 = 32'hDEADBEEF via the register file while record 3 waits -> record 5 reports 32'hDEADBEEF.
REQ-040 Assert rst and start in the same cycle -> remains in IDLE, busy=0.

Source files
------------

// File: rtl/rf_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: FSM state encoding
// and the register-file geometry constants that the dump walks over.
package rf_dump_reader_pkg;

    // Register-file geometry: 32 registers addressed by a 5-bit index.
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    // Dump sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } dump_state_e;

endpackage : rf_dump_reader_pkg

// File: rtl/rf_dump_reader.sv
// Register-file dump reader. On a start request it walks the read port of a
// register file from address 0 to NUM_REGS-1 and presents each register as
// one valid/ready record (register number, value, last flag). Each record is
// sampled in its own READ cycle, so the dump is not an atomic snapshot.
// The block only drives a read address; it has no write path.
module rf_dump_reader #(
    parameter int NUM_REGS = rf_dump_reader_pkg::NUM_REGS,
    parameter int ADDR_W   = rf_dump_reader_pkg::ADDR_W,
    parameter int DATA_W   = rf_dump_reader_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_regnum,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    import rf_dump_reader_pkg::*;

    // Highest address the counter may ever reach; it never steps past this.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    // FSM state
    dump_state_e       state_r;
    dump_state_e       state_nxt_s;

    // Registered outputs
    logic [ADDR_W-1:0] rd_addr_r;
    logic              out_valid_r;
    logic [ADDR_W-1:0] out_regnum_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_last_r;
    logic              busy_r;
    logic              done_r;

    // Next values for the registered outputs
    logic [ADDR_W-1:0] rd_addr_nxt_s;
    logic              out_valid_nxt_s;
    logic [ADDR_W-1:0] out_regnum_nxt_s;
    logic [DATA_W-1:0] out_data_nxt_s;
    logic              out_last_nxt_s;
    logic              busy_nxt_s;
    logic              done_nxt_s;

    // Helper conditions
    logic              handshake_s;
    logic              at_last_s;

    // Record accepted by the consumer this cycle; the address counter is at the final register.
    assign handshake_s = out_valid_r & out_ready;
    assign at_last_s   = (rd_addr_r == LAST_ADDR);

    // State register: reset wins over everything, including a same-cycle start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: start is only honoured in IDLE, so it is ignored while busy and in DONE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                state_nxt_s = ST_HOLD;
            end
            ST_HOLD: begin
                if (handshake_s) begin
                    if (at_last_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_READ;
                    end
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: computes the next value of every registered output from the current state.
    always_comb begin
        rd_addr_nxt_s    = rd_addr_r;
        out_regnum_nxt_s = out_regnum_r;
        out_data_nxt_s   = out_data_r;
        out_last_nxt_s   = out_last_r;
        // Status flags follow the state being entered so they line up with it.
        out_valid_nxt_s  = (state_nxt_s == ST_HOLD);
        busy_nxt_s       = (state_nxt_s != ST_IDLE);
        done_nxt_s       = (state_nxt_s == ST_DONE);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    rd_addr_nxt_s = '0;
                end else begin
                    rd_addr_nxt_s = rd_addr_r;
                end
            end
            ST_READ: begin
                // Capture the register as it is right now; later writes show up in later records only.
                out_regnum_nxt_s = rd_addr_r;
                out_data_nxt_s   = rd_data;
                out_last_nxt_s   = at_last_s;
            end
            ST_HOLD: begin
                if (handshake_s) begin
                    // Last flag must drop together with valid.
                    out_last_nxt_s = 1'b0;
                    if (at_last_s) begin
                        rd_addr_nxt_s = rd_addr_r;
                    end else begin
                        rd_addr_nxt_s = rd_addr_r + ADDR_W'(1);
                    end
                end else begin
                    out_last_nxt_s = out_last_r;
                end
            end
            ST_DONE: begin
                rd_addr_nxt_s = rd_addr_r;
            end
            default: begin
                out_last_nxt_s = 1'b0;
            end
        endcase
    end

    // Output registers: cleared by reset so an aborted dump leaves no record or done pulse behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_r    <= '0;
            out_valid_r  <= 1'b0;
            out_regnum_r <= '0;
            out_data_r   <= '0;
            out_last_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            rd_addr_r    <= rd_addr_nxt_s;
            out_valid_r  <= out_valid_nxt_s;
            out_regnum_r <= out_regnum_nxt_s;
            out_data_r   <= out_data_nxt_s;
            out_last_r   <= out_last_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
        end
    end

    assign rd_addr    = rd_addr_r;
    assign out_valid  = out_valid_r;
    assign out_regnum = out_regnum_r;
    assign out_data   = out_data_r;
    assign out_last   = out_last_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule : rf_dump_reader

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader with a behavioural register file whose
// read port is combinational. Expected values come from hand-derived
// constants: reg i holds 32'hA5A50000+i unless overwritten by the bench.
module tb_rf_dump_reader;

    localparam int N  = 32;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_regnum;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] regs [N];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Behavioural register file read port
    assign rd_data = regs[rd_addr];

    rf_dump_reader #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_regnum (out_regnum),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    // Advance one clock and settle past the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload();
        for (int i = 0; i < N; i++) begin
            regs[i] = 32'hA5A50000 + 32'(i);
        end
    endtask

    // Runs one dump. Start is presented in the cycle ending at edge 0; edge k
    // is counted from there. With no stalls DONE is visible after edge 64,
    // i.e. in the 66th cycle counting the start cycle (2*N+2 inclusive).
    task automatic run_dump(input string name, input int stall_rec, input int stall_len,
                            input int restart_rec, input bit do_write, input int exp_done_k);
        int exp_idx   = 0;
        int stalled   = 0;
        int done_cnt  = 0;
        int done_k    = -1;
        int last_cnt  = 0;
        bit restarted = 1'b0;
        logic [DW-1:0] exp_data;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            start     = 1'b0;
            out_ready = 1'b1;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
                chk({name, " busy_in_done"}, 64'(busy), 64'd1);
            end
            if (out_valid === 1'b1) begin
                exp_data = (do_write && exp_idx == 5) ? 32'hDEADBEEF : 32'hA5A50000 + 32'(exp_idx);
                if (out_last === 1'b1) last_cnt++;
                chk({name, " regnum"}, 64'(out_regnum), 64'(exp_idx));
                chk({name, " data"}, 64'(out_data), 64'(exp_data));
                chk({name, " last"}, 64'(out_last), 64'(exp_idx == N - 1));
                chk({name, " rd_addr_hold"}, 64'(rd_addr), 64'(exp_idx));
                chk({name, " busy_valid"}, 64'(busy), 64'd1);
                if (exp_idx == stall_rec && stalled < stall_len) begin
                    out_ready = 1'b0;
                    if (do_write && stalled == 0) regs[5] = 32'hDEADBEEF;
                    stalled++;
                end else begin
                    if (exp_idx == restart_rec && !restarted) begin
                        start     = 1'b1;
                        restarted = 1'b1;
                    end
                    exp_idx++;
                end
            end else begin
                chk({name, " last_low_when_invalid"}, 64'(out_last), 64'd0);
            end
        end
        chk({name, " records"}, 64'(exp_idx), 64'(N));
        chk({name, " last_count"}, 64'(last_cnt), 64'd1);
        chk({name, " done_count"}, 64'(done_cnt), 64'd1);
        chk({name, " done_edge"}, 64'(done_k), 64'(exp_done_k));
        chk({name, " idle_busy"}, 64'(busy), 64'd0);
        chk({name, " rd_addr_idle"}, 64'(rd_addr), 64'(N - 1));
    endtask

    initial begin
        bit found;
        preload();
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst rd_addr", 64'(rd_addr), 64'd0);
        chk("rst out_regnum", 64'(out_regnum), 64'd0);
        chk("rst out_data", 64'(out_data), 64'd0);
        chk("rst out_last", 64'(out_last), 64'd0);

        // Reset and start together: reset wins, stays idle
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_start busy", 64'(busy), 64'd0);
        chk("rst_start valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        tick();
        chk("rst_start idle busy", 64'(busy), 64'd0);
        tick();
        chk("rst_start idle valid", 64'(out_valid), 64'd0);

        // Plain full dump with ready held high
        run_dump("full", -1, 0, -1, 1'b0, 64);

        // Stall record 7 for 5 cycles and pulse start at record 10
        run_dump("stall_restart", 7, 5, 10, 1'b0, 69);

        // Overwrite reg 5 while record 3 waits; record 5 must see the new value
        run_dump("write", 3, 2, -1, 1'b1, 66);
        preload();

        // Reset during HOLD of record 20
        found     = 1'b0;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            tick();
            if (out_valid === 1'b1 && out_regnum == AW'(20)) found = 1'b1;
        end
        chk("abort reached rec20", 64'(found), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort valid", 64'(out_valid), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort last", 64'(out_last), 64'd0);
        chk("abort rd_addr", 64'(rd_addr), 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("abort quiet done", 64'(done), 64'd0);
            chk("abort quiet busy", 64'(busy), 64'd0);
        end

        // A new start after the abort dumps from register 0
        run_dump("after_abort", -1, 0, -1, 1'b0, 64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rf_dump_reader
